// File: rtl/multicycle_core.sv
// multicycle_core: multicycle MIPS-subset core with req/ack instruction and data memory ports
module multicycle_core #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [RA_W-1:0]   dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  output logic [DATA_W-1:0] pc_out,
  output logic [3:0]        state_out,
  output logic              instr_done,
  output logic              illegal
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_RWB, S_ADDR, S_IWB, S_MRD, S_LWB, S_MWR, S_BRANCH, S_JUMP
  } state_t;

  state_t state, state_nx;
  logic [DATA_W-1:0] pc, a, b, alu_out, mdr, alu_r, imm, tgt, wd;
  logic [DATA_W-1:0] regs [NREGS];
  logic [31:0] ir, imm32, tgt32;
  logic [5:0] op, funct;
  logic [RA_W-1:0] rs, rt, rd, wa;
  logic r_ok, mem_op, we, unused_ok;

  assign op        = ir[31:26];
  assign funct     = ir[5:0];
  assign rs        = ir[21 +: RA_W];
  assign rt        = ir[16 +: RA_W];
  assign rd        = ir[11 +: RA_W];
  assign imm32     = {{16{ir[15]}}, ir[15:0]};
  assign tgt32     = {6'd0, ir[25:0]};
  assign imm       = imm32[DATA_W-1:0];
  assign tgt       = tgt32[DATA_W-1:0];
  assign unused_ok = ^{ir, imm32, tgt32};
  assign r_ok      = op == OP_R && funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign mem_op    = op inside {OP_LW, OP_SW, OP_ADDI};

  assign alu_r = funct == F_SUB ? a - b :
                 funct == F_AND ? a & b :
                 funct == F_OR  ? a | b :
                 funct == F_SLT ? {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)} : a + b;

  assign we = state inside {S_RWB, S_IWB, S_LWB};
  assign wa = state == S_RWB ? rd : rt;
  assign wd = state == S_LWB ? mdr : alu_out;

  always_ff @(posedge clk)
    if (rst) state <= S_FETCH;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = r_ok ? S_EXEC : mem_op ? S_ADDR : op == OP_BEQ ? S_BRANCH :
                           op == OP_J ? S_JUMP : S_FETCH;
      S_EXEC:   state_nx = S_RWB;
      S_ADDR:   state_nx = op == OP_ADDI ? S_IWB : op == OP_LW ? S_MRD : S_MWR;
      S_MRD:    state_nx = dmem_ack ? S_LWB : S_MRD;
      S_MWR:    state_nx = dmem_ack ? S_FETCH : S_MWR;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Gating with rst keeps every request quiet while reset is held
  always_comb begin
    imem_req   = state == S_FETCH && !rst;
    dmem_req   = state inside {S_MRD, S_MWR} && !rst;
    dmem_we    = state == S_MWR && !rst;
    instr_done = !rst && (state inside {S_RWB, S_IWB, S_LWB, S_BRANCH, S_JUMP} ||
                          (state == S_MWR && dmem_ack));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we && wa != '0) regs[wa] <= wd;
      case (state)
        S_FETCH: if (imem_ack) begin
          ir <= imem_rdata;
          pc <= pc + DATA_W'(1);
        end
        S_DECODE: begin
          a <= regs[rs];
          b <= regs[rt];
          if (!(r_ok || mem_op || op == OP_BEQ || op == OP_J)) illegal <= 1'b1;
        end
        S_EXEC:   alu_out <= alu_r;
        S_ADDR:   alu_out <= a + imm;
        S_MRD:    if (dmem_ack) mdr <= dmem_rdata;
        S_BRANCH: if (a == b) pc <= pc + imm;
        S_JUMP:   pc <= tgt;
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b;
  assign dbg_rd     = regs[dbg_ra];
  assign state_out  = state;
endmodule
